// File: rtl/ram_sync_read_dp_if.sv
// Bus bundle for ram_sync_read_dp: clear request, write port, read port.
// The master drives requests; the slave (the RAM) returns busy and read data.
interface ram_sync_read_dp_if #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 32
);
    localparam int NBYTES = DWIDTH / 8;

    logic              clr_start;
    logic              busy;
    logic              wr_en;
    logic [AWIDTH-1:0] wr_addr;
    logic [DWIDTH-1:0] wr_data;
    logic [NBYTES-1:0] wr_be;
    logic              rd_en;
    logic [AWIDTH-1:0] rd_addr;
    logic [DWIDTH-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output clr_start, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  busy, rd_data, rd_valid
    );

    modport slave (
        input  clr_start, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output busy, rd_data, rd_valid
    );
endinterface

// File: rtl/ram_sync_read_dp.sv
// Dual-port sync-read RAM with byte enables and a hardware clear sweep.
// Define RAM_BYPASS_EN to forward same-cycle write data to a colliding read.
module ram_sync_read_dp #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 32
) (
    input logic                clock,
    input logic                reset_n,
    ram_sync_read_dp_if.slave  bus
);
    localparam int DEPTH  = 1 << AWIDTH;
    localparam int NBYTES = DWIDTH / 8;

    typedef enum logic [1:0] {
        S_INIT,
        S_CLEAR,
        S_IDLE
    } state_e;

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic [DWIDTH-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [DWIDTH-1:0] rd_word;
    logic              busy;

    assign busy         = (state_q != S_IDLE);
    assign bus.busy     = busy;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_INIT;
            clr_cnt_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            S_INIT, S_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1) begin
                    state_d   = S_IDLE;
                    clr_cnt_d = '0;
                end
            end
            S_IDLE: begin
                if (bus.clr_start) state_d = S_CLEAR;
            end
            default: state_d = S_INIT;
        endcase
    end

    // Collision policy: old word unless bypass forwards the written lanes
    always_comb begin
        rd_word = mem_q[bus.rd_addr];
`ifdef RAM_BYPASS_EN
        if (bus.wr_en && (bus.wr_addr == bus.rd_addr)) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (bus.wr_be[i]) rd_word[8*i +: 8] = bus.wr_data[8*i +: 8];
            end
        end
`endif
    end

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (!busy && bus.rd_en) begin
            rd_data_d  = rd_word;
            rd_valid_d = 1'b1;
        end
    end

    // Array has no reset; the INIT sweep zeroes it instead
    always_ff @(posedge clock) begin
        if (busy) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (bus.wr_en) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (bus.wr_be[i]) begin
                    mem_q[bus.wr_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_ram_sync_read_dp.sv
// Randomised and directed bench for ram_sync_read_dp against an
// array-based reference model, with literal checks on the key scenarios.
module tb_ram_sync_read_dp;
    localparam int AW    = 3;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;
    localparam int NB    = DW / 8;

    logic clk = 1'b0;
    logic rst_n;
    logic cmp_en = 1'b0;

    int checks = 0;
    int errors = 0;

    ram_sync_read_dp_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    ram_sync_read_dp #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: clear countdown, word array, expected read outputs
    int          m_clr_left;
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_rd_data;
    logic        m_rd_valid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_clr_left <= DEPTH;
            m_rd_data  <= '0;
            m_rd_valid <= 1'b0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] <= 32'hFFFF_FFFF;
        end else if (m_clr_left > 0) begin
            m_mem[DEPTH - m_clr_left] <= '0;
            m_clr_left <= m_clr_left - 1;
            m_rd_valid <= 1'b0;
        end else begin
            if (bus.rd_en) begin
                logic [31:0] w;
                w = m_mem[bus.rd_addr];
`ifdef RAM_BYPASS_EN
                if (bus.wr_en && bus.wr_addr == bus.rd_addr)
                    for (int i = 0; i < NB; i++)
                        if (bus.wr_be[i]) w[8*i +: 8] = bus.wr_data[8*i +: 8];
`endif
                m_rd_data <= w;
            end
            m_rd_valid <= bus.rd_en;
            if (bus.wr_en)
                for (int i = 0; i < NB; i++)
                    if (bus.wr_be[i])
                        m_mem[bus.wr_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
            if (bus.clr_start) m_clr_left <= DEPTH;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", {31'd0, bus.busy}, {31'd0, m_clr_left > 0});
            chk("rd_valid", {31'd0, bus.rd_valid}, {31'd0, m_rd_valid});
            chk("rd_data", bus.rd_data, m_rd_data);
        end
    end

    task automatic quiet();
        bus.clr_start = 1'b0;
        bus.wr_en     = 1'b0;
        bus.rd_en     = 1'b0;
        bus.wr_be     = '0;
    endtask

    task automatic op(input logic we, input logic [AW-1:0] wa,
                      input logic [31:0] wd, input logic [NB-1:0] be,
                      input logic re, input logic [AW-1:0] ra,
                      input logic cs);
        bus.wr_en     = we;
        bus.wr_addr   = wa;
        bus.wr_data   = wd;
        bus.wr_be     = be;
        bus.rd_en     = re;
        bus.rd_addr   = ra;
        bus.clr_start = cs;
        @(negedge clk);
        quiet();
    endtask

    task automatic count_busy(input string name);
        int n;
        n = 0;
        while (bus.busy && n < 40) begin
            bus.wr_en   = 1'($urandom);
            bus.wr_addr = AW'($urandom);
            bus.wr_data = 32'hFFFF_FFFF;
            bus.wr_be   = '1;
            bus.rd_en   = 1'($urandom);
            bus.rd_addr = AW'($urandom);
            @(negedge clk);
            n++;
        end
        quiet();
        chk(name, n, DEPTH);
    endtask

    task automatic read_all_zero(input string name);
        for (int a = 0; a < DEPTH; a++) begin
            op(0, 0, 0, 0, 1, AW'(a), 0);
            chk(name, bus.rd_data, 32'h0);
            chk({name, "_v"}, {31'd0, bus.rd_valid}, 32'd1);
        end
    endtask

    logic [31:0] coll_exp;

    initial begin
        quiet();
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_addr = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        count_busy("init_busy_len");
        read_all_zero("init_zero");

        op(1, 5, 32'hDEAD_BEEF, 4'b1111, 0, 0, 0);
        op(0, 0, 0, 0, 1, 5, 0);
        chk("rd5", bus.rd_data, 32'hDEAD_BEEF);
        chk("rd5_v", {31'd0, bus.rd_valid}, 32'd1);
        op(0, 0, 0, 0, 0, 0, 0);
        chk("rd5_hold", bus.rd_data, 32'hDEAD_BEEF);
        chk("rd5_nv", {31'd0, bus.rd_valid}, 32'd0);

        op(1, 2, 32'h1122_3344, 4'b1111, 0, 0, 0);
        op(1, 2, 32'hAABB_CCDD, 4'b0101, 0, 0, 0);
        op(0, 0, 0, 0, 1, 2, 0);
        chk("byte_en", bus.rd_data, 32'h11BB_33DD);

`ifdef RAM_BYPASS_EN
        coll_exp = 32'hCAFE_F00D;
`else
        coll_exp = 32'h1234_5678;
`endif
        op(1, 3, 32'h1234_5678, 4'b1111, 0, 0, 0);
        op(1, 3, 32'hCAFE_F00D, 4'b1111, 1, 3, 0);
        chk("collision", bus.rd_data, coll_exp);
        op(0, 0, 0, 0, 1, 3, 0);
        chk("after_coll", bus.rd_data, 32'hCAFE_F00D);

        for (int a = 0; a < DEPTH; a++) op(1, AW'(a), 32'hFFFF_FFFF, 4'b1111, 0, 0, 0);
        op(1, 1, 32'h5555_5555, 4'b1111, 0, 0, 1);
        count_busy("clr_busy_len");
        read_all_zero("clr_zero");

        for (int a = 0; a < DEPTH; a++) op(1, AW'(a), 32'hFFFF_FFFF, 4'b1111, 0, 0, 0);
        op(0, 0, 0, 0, 0, 0, 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_busy("rst_busy_len");
        read_all_zero("rst_zero");

        for (int c = 0; c < 600; c++) begin
            logic [AW-1:0] wa;
            wa = AW'($urandom);
            op(1'($urandom), wa, $urandom, NB'($urandom),
               1'($urandom), ($urandom_range(0, 3) == 0) ? wa : AW'($urandom),
               ($urandom_range(0, 60) == 0));
        end
        repeat (DEPTH + 2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
